// File: rtl/font_rom_arbiter_if.sv
// Requester/ROM bundle for the font ROM arbiter: two read ports plus the shared ROM side.
// slave = arbiter view, master = requesters and ROM view.
interface font_rom_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic              gnt_a;
  logic              valid_a;
  logic [DATA_W-1:0] data_a;

  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic              gnt_b;
  logic              valid_b;
  logic [DATA_W-1:0] data_b;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req_a, addr_a, req_b, addr_b, rom_data,
    output gnt_a, valid_a, data_a, gnt_b, valid_b, data_b, rom_addr
  );

  modport master (
    output req_a, addr_a, req_b, addr_b, rom_data,
    input  gnt_a, valid_a, data_a, gnt_b, valid_b, data_b, rom_addr
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Shares one font ROM between ports A and B; one grant per cycle, row returned ROM_LAT+2 cycles
// after grant. No backpressure on returns: a requester simply holds req until gnt.
module font_rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int RR_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  font_rom_arbiter_if.slave    bus
);

  localparam logic [0:0] PTR_A = 1'b0;
  localparam logic [0:0] PTR_B = 1'b1;

  logic [0:0]             rr_ptr_q, rr_ptr_d;
  logic                   gnt_a, gnt_b;
  logic [ADDR_W-1:0]      rom_addr_q;
  logic [ROM_LAT:0][1:0]  tag_q;
  logic                   valid_a_q, valid_b_q;
  logic [DATA_W-1:0]      data_a_q, data_b_q;

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!rst) begin
      if (bus.req_a && bus.req_b) begin
        if (RR_EN == 0 || rr_ptr_q == PTR_A) gnt_a = 1'b1;
        else                                 gnt_b = 1'b1;
      end else begin
        gnt_a = bus.req_a;
        gnt_b = bus.req_b;
      end
    end
    if (gnt_a)      rr_ptr_d = PTR_B;
    else if (gnt_b) rr_ptr_d = PTR_A;
  end

  // tag_q[k] travels alongside the access; stage ROM_LAT lines up with rom_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= PTR_A;
      rom_addr_q <= '0;
      tag_q      <= '0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (gnt_a)      rom_addr_q <= bus.addr_a;
      else if (gnt_b) rom_addr_q <= bus.addr_b;
      tag_q     <= {tag_q[ROM_LAT-1:0], {gnt_a, gnt_b}};
      valid_a_q <= tag_q[ROM_LAT][1];
      valid_b_q <= tag_q[ROM_LAT][0];
      if (tag_q[ROM_LAT][1]) data_a_q <= bus.rom_data;
      if (tag_q[ROM_LAT][0]) data_b_q <= bus.rom_data;
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rom_addr = rom_addr_q;
  assign bus.valid_a  = valid_a_q;
  assign bus.valid_b  = valid_b_q;
  assign bus.data_a   = data_a_q;
  assign bus.data_b   = data_b_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench: three arbiter builds (RR/LAT1, fixed/LAT1, RR/LAT3) each fed by a small ROM model.
module tb_font_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b;
  logic [10:0] addr_a, addr_b;
  int          sel;
  int          errors = 0;
  int          checks = 0;

  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) if0 ();
  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) if1 ();
  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) if2 ();

  font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .RR_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .RR_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(3), .RR_EN(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a == 11'h318) return 8'h3C;
    return a[7:0] ^ {5'b0, a[10:8]};
  endfunction

  logic [7:0] rom0_q, rom1_q, rom2_p1, rom2_p2, rom2_q;
  always_ff @(posedge clk) begin
    rom0_q  <= rom_fn(if0.rom_addr);
    rom1_q  <= rom_fn(if1.rom_addr);
    rom2_p1 <= rom_fn(if2.rom_addr);
    rom2_p2 <= rom2_p1;
    rom2_q  <= rom2_p2;
  end

  assign if0.req_a = req_a && (sel == 0);
  assign if0.req_b = req_b && (sel == 0);
  assign if0.addr_a = addr_a;
  assign if0.addr_b = addr_b;
  assign if0.rom_data = rom0_q;
  assign if1.req_a = req_a && (sel == 1);
  assign if1.req_b = req_b && (sel == 1);
  assign if1.addr_a = addr_a;
  assign if1.addr_b = addr_b;
  assign if1.rom_data = rom1_q;
  assign if2.req_a = req_a && (sel == 2);
  assign if2.req_b = req_b && (sel == 2);
  assign if2.addr_a = addr_a;
  assign if2.addr_b = addr_b;
  assign if2.rom_data = rom2_q;

  logic        o_ga, o_gb, o_va, o_vb;
  logic [7:0]  o_da, o_db;
  logic [10:0] o_ra;
  assign o_ga = (sel == 0) ? if0.gnt_a    : (sel == 1) ? if1.gnt_a    : if2.gnt_a;
  assign o_gb = (sel == 0) ? if0.gnt_b    : (sel == 1) ? if1.gnt_b    : if2.gnt_b;
  assign o_va = (sel == 0) ? if0.valid_a  : (sel == 1) ? if1.valid_a  : if2.valid_a;
  assign o_vb = (sel == 0) ? if0.valid_b  : (sel == 1) ? if1.valid_b  : if2.valid_b;
  assign o_da = (sel == 0) ? if0.data_a   : (sel == 1) ? if1.data_a   : if2.data_a;
  assign o_db = (sel == 0) ? if0.data_b   : (sel == 1) ? if1.data_b   : if2.data_b;
  assign o_ra = (sel == 0) ? if0.rom_addr : (sel == 1) ? if1.rom_addr : if2.rom_addr;

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    sel = 0; rst = 1'b1; req_a = 1'b1; req_b = 1'b1; addr_a = 11'h318; addr_b = 11'h200;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 3) begin rst = 1'b0; req_a = 1'b0; req_b = 1'b0; end
      @(negedge clk);
      checks++; if (o_ga !== 1'b0 || o_gb !== 1'b0) begin errors++; $display("FAIL reset_gnt c=%0d got a=%b b=%b exp 0 0", c, o_ga, o_gb); end
      checks++; if (o_va !== 1'b0 || o_vb !== 1'b0) begin errors++; $display("FAIL reset_valid c=%0d got a=%b b=%b exp 0 0", c, o_va, o_vb); end
      checks++; if (o_da !== 8'h00 || o_db !== 8'h00) begin errors++; $display("FAIL reset_data c=%0d got a=%h b=%h exp 00 00", c, o_da, o_db); end
      checks++; if (o_ra !== 11'h000) begin errors++; $display("FAIL reset_rom_addr c=%0d got %h exp 000", c, o_ra); end
    end
  endtask

  task automatic test_single_a;
    logic [10:0] e_ra;
    do_reset(); sel = 0; addr_a = 11'h318;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req_a = (c == 0);
      @(negedge clk);
      e_ra = (c >= 1) ? 11'h318 : 11'h000;
      checks++; if (o_ga !== (c == 0) || o_gb !== 1'b0) begin errors++; $display("FAIL single_gnt c=%0d got a=%b b=%b exp a=%b b=0", c, o_ga, o_gb, c == 0); end
      checks++; if (o_ra !== e_ra) begin errors++; $display("FAIL single_rom_addr c=%0d got %h exp %h", c, o_ra, e_ra); end
      checks++; if (o_va !== (c == 3) || o_vb !== 1'b0) begin errors++; $display("FAIL single_valid c=%0d got a=%b b=%b exp a=%b b=0", c, o_va, o_vb, c == 3); end
      checks++; if (o_da !== ((c >= 3) ? 8'h3C : 8'h00)) begin errors++; $display("FAIL single_data c=%0d got %h exp %h", c, o_da, (c >= 3) ? 8'h3C : 8'h00); end
    end
  endtask

  task automatic test_round_robin;
    logic e_ga, e_gb, e_va, e_vb;
    logic [10:0] e_ra;
    do_reset(); sel = 0; addr_a = 11'h100; addr_b = 11'h200;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req_a = (c < 8); req_b = (c < 8);
      @(negedge clk);
      e_ga = (c < 8) && (c % 2 == 0);
      e_gb = (c < 8) && (c % 2 == 1);
      e_va = (c >= 3) && (c <= 9) && (c % 2 == 1);
      e_vb = (c >= 4) && (c <= 10) && (c % 2 == 0);
      e_ra = (c == 0) ? 11'h000 : ((c <= 8) && (c % 2 == 1)) ? 11'h100 : 11'h200;
      checks++; if (o_ga !== e_ga || o_gb !== e_gb) begin errors++; $display("FAIL rr_gnt c=%0d got a=%b b=%b exp a=%b b=%b", c, o_ga, o_gb, e_ga, e_gb); end
      checks++; if (o_va !== e_va || o_vb !== e_vb) begin errors++; $display("FAIL rr_valid c=%0d got a=%b b=%b exp a=%b b=%b", c, o_va, o_vb, e_va, e_vb); end
      checks++; if (o_ra !== e_ra) begin errors++; $display("FAIL rr_rom_addr c=%0d got %h exp %h", c, o_ra, e_ra); end
      checks++; if (o_da !== ((c >= 3) ? 8'h01 : 8'h00) || o_db !== ((c >= 4) ? 8'h02 : 8'h00)) begin
        errors++; $display("FAIL rr_data c=%0d got a=%h b=%h", c, o_da, o_db); end
    end
  endtask

  task automatic test_fixed_priority;
    logic e_ga, e_gb, e_va, e_vb;
    do_reset(); sel = 1; addr_a = 11'h100; addr_b = 11'h200;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      req_a = (c < 8); req_b = (c < 10);
      @(negedge clk);
      e_ga = (c < 8);
      e_gb = (c == 8) || (c == 9);
      e_va = (c >= 3) && (c <= 10);
      e_vb = (c == 11) || (c == 12);
      checks++; if (o_ga !== e_ga || o_gb !== e_gb) begin errors++; $display("FAIL fixed_gnt c=%0d got a=%b b=%b exp a=%b b=%b", c, o_ga, o_gb, e_ga, e_gb); end
      checks++; if (o_va !== e_va || o_vb !== e_vb) begin errors++; $display("FAIL fixed_valid c=%0d got a=%b b=%b exp a=%b b=%b", c, o_va, o_vb, e_va, e_vb); end
      checks++; if (o_da !== ((c >= 3) ? 8'h01 : 8'h00) || o_db !== ((c >= 11) ? 8'h02 : 8'h00)) begin
        errors++; $display("FAIL fixed_data c=%0d got a=%h b=%h", c, o_da, o_db); end
    end
  endtask

  task automatic test_back_to_back_lat3;
    logic [7:0]  e_da, e_db;
    logic [10:0] e_ra;
    do_reset(); sel = 2;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req_a = (c == 0) || (c == 2);
      req_b = (c == 1);
      addr_a = (c < 2) ? 11'h141 : 11'h533;
      addr_b = 11'h2A7;
      @(negedge clk);
      e_ra = (c == 0) ? 11'h000 : (c == 1) ? 11'h141 : (c == 2) ? 11'h2A7 : 11'h533;
      e_da = (c < 5) ? 8'h00 : (c < 7) ? 8'h40 : 8'h36;
      e_db = (c < 6) ? 8'h00 : 8'hA5;
      checks++; if (o_ga !== (c == 0 || c == 2) || o_gb !== (c == 1)) begin errors++; $display("FAIL lat3_gnt c=%0d got a=%b b=%b", c, o_ga, o_gb); end
      checks++; if (o_ra !== e_ra) begin errors++; $display("FAIL lat3_rom_addr c=%0d got %h exp %h", c, o_ra, e_ra); end
      checks++; if (o_va !== (c == 5 || c == 7) || o_vb !== (c == 6)) begin errors++; $display("FAIL lat3_valid c=%0d got a=%b b=%b", c, o_va, o_vb); end
      checks++; if (o_da !== e_da || o_db !== e_db) begin errors++; $display("FAIL lat3_data c=%0d got a=%h b=%h exp a=%h b=%h", c, o_da, o_db, e_da, e_db); end
    end
  endtask

  task automatic test_reset_inflight;
    do_reset(); sel = 0; addr_a = 11'h100; addr_b = 11'h200;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      rst   = (c == 2);
      req_b = (c == 0) || (c == 2) || (c == 5);
      req_a = (c == 1) || (c == 2) || (c == 5);
      @(negedge clk);
      checks++; if (o_ga !== (c == 1 || c == 5) || o_gb !== (c == 0)) begin errors++; $display("FAIL rst_mid_gnt c=%0d got a=%b b=%b", c, o_ga, o_gb); end
      checks++; if (o_va !== (c == 8) || o_vb !== 1'b0) begin errors++; $display("FAIL rst_mid_valid c=%0d got a=%b b=%b exp a=%b b=0", c, o_va, o_vb, c == 8); end
      checks++; if (o_da !== ((c >= 8) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL rst_mid_data c=%0d got %h", c, o_da); end
    end
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0; sel = 0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back_lat3();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
